// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: requester identity used for
// grant bookkeeping and for tagging outstanding reads.
package mem_arb_pkg;

    typedef enum logic {
        REQ_DATA  = 1'b0,
        REQ_FETCH = 1'b1
    } req_e;

endpackage

// File: rtl/req_tag_fifo.sv
// In-order FIFO of requester tags, one entry per read in flight; the head
// entry names the requester that owns the next memory response.
module req_tag_fifo
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  req_e                     push_tag,
    input  logic                     pop,
    output req_e                     head_tag,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    req_e            mem_q [DEPTH];
    req_e            mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push;
    logic            do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign head_tag = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_tag;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= REQ_DATA;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between execute-stage
// load/store and instruction fetch, with in-order read response routing.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MASK_W  = 8,
    parameter int MAX_OUT = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       d_write_in,
    input  logic                       d_read_in,
    input  logic [ADDR_W-1:0]          d_addr_in,
    input  logic [DATA_W-1:0]          d_wdata_in,
    input  logic [MASK_W-1:0]          d_mask_in,
    output logic                       d_ready_out,
    output logic                       d_rvalid_out,
    output logic [DATA_W-1:0]          d_rdata_out,
    input  logic                       f_read_in,
    input  logic [ADDR_W-1:0]          f_addr_in,
    output logic                       f_ready_out,
    output logic                       f_rvalid_out,
    output logic [DATA_W-1:0]          f_rdata_out,
    output logic                       m_write_out,
    output logic                       m_read_out,
    output logic [ADDR_W-1:0]          m_addr_out,
    output logic [DATA_W-1:0]          m_wdata_out,
    output logic [MASK_W-1:0]          m_mask_out,
    input  logic                       m_ready_in,
    input  logic                       m_rvalid_in,
    input  logic [DATA_W-1:0]          m_rdata_in,
    output logic [$clog2(MAX_OUT):0]   outstanding_out,
    output logic                       error_out
);
    req_e  last_grant_q, last_grant_d;
    logic  error_q, error_d;
    req_e  grant;
    logic  grant_vld;
    logic  is_write;
    logic  is_read;
    logic  accept;
    logic  rsp_vld;
    req_e  head_tag;
    logic  fifo_full;
    logic  fifo_empty;

    always_comb begin
        grant_vld = d_write_in || d_read_in || f_read_in;
        grant     = REQ_DATA;
        if ((d_write_in || d_read_in) && f_read_in) begin
            grant = (last_grant_q == REQ_DATA) ? REQ_FETCH : REQ_DATA;
        end else if (f_read_in) begin
            grant = REQ_FETCH;
        end
        // A simultaneous load+store is issued as the store alone.
        is_write = grant_vld && (grant == REQ_DATA) && d_write_in;
        is_read  = grant_vld && !is_write;
        accept   = reset && grant_vld && m_ready_in && (is_write || !fifo_full);
    end

    always_comb begin
        m_write_out = is_write;
        m_read_out  = is_read && !fifo_full;
        m_addr_out  = '0;
        m_wdata_out = '0;
        m_mask_out  = '0;
        if (grant_vld && grant == REQ_DATA) begin
            m_addr_out  = d_addr_in;
            m_wdata_out = d_wdata_in;
            m_mask_out  = d_mask_in;
        end else if (grant_vld) begin
            m_addr_out = f_addr_in;
        end
        d_ready_out = accept && (grant == REQ_DATA);
        f_ready_out = accept && (grant == REQ_FETCH);
    end

    always_comb begin
        rsp_vld      = reset && m_rvalid_in && !fifo_empty;
        d_rvalid_out = rsp_vld && (head_tag == REQ_DATA);
        f_rvalid_out = rsp_vld && (head_tag == REQ_FETCH);
        d_rdata_out  = d_rvalid_out ? m_rdata_in : '0;
        f_rdata_out  = f_rvalid_out ? m_rdata_in : '0;
    end

    always_comb begin
        last_grant_d = accept ? grant : last_grant_q;
        error_d      = error_q || (m_rvalid_in && fifo_empty);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_q <= REQ_FETCH;
            error_q      <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            error_q      <= error_d;
        end
    end

    assign error_out = error_q;

    req_tag_fifo #(
        .DEPTH (MAX_OUT)
    ) u_tag_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (accept && is_read),
        .push_tag (grant),
        .pop      (rsp_vld),
        .head_tag (head_tag),
        .count    (outstanding_out),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed vector bench for mem_port_arbiter: sequential stimulus table plus
// reset-separated sequences for contention, back-pressure and reset corners.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        d_write_in, d_read_in;
    logic [31:0] d_addr_in, d_wdata_in;
    logic [7:0]  d_mask_in;
    logic        d_ready_out, d_rvalid_out;
    logic [31:0] d_rdata_out;
    logic        f_read_in;
    logic [31:0] f_addr_in;
    logic        f_ready_out, f_rvalid_out;
    logic [31:0] f_rdata_out;
    logic        m_write_out, m_read_out;
    logic [31:0] m_addr_out, m_wdata_out;
    logic [7:0]  m_mask_out;
    logic        m_ready_in, m_rvalid_in;
    logic [31:0] m_rdata_in;
    logic [2:0]  outstanding_out;
    logic        error_out;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .d_write_in      (d_write_in),
        .d_read_in       (d_read_in),
        .d_addr_in       (d_addr_in),
        .d_wdata_in      (d_wdata_in),
        .d_mask_in       (d_mask_in),
        .d_ready_out     (d_ready_out),
        .d_rvalid_out    (d_rvalid_out),
        .d_rdata_out     (d_rdata_out),
        .f_read_in       (f_read_in),
        .f_addr_in       (f_addr_in),
        .f_ready_out     (f_ready_out),
        .f_rvalid_out    (f_rvalid_out),
        .f_rdata_out     (f_rdata_out),
        .m_write_out     (m_write_out),
        .m_read_out      (m_read_out),
        .m_addr_out      (m_addr_out),
        .m_wdata_out     (m_wdata_out),
        .m_mask_out      (m_mask_out),
        .m_ready_in      (m_ready_in),
        .m_rvalid_in     (m_rvalid_in),
        .m_rdata_in      (m_rdata_in),
        .outstanding_out (outstanding_out),
        .error_out       (error_out)
    );

    typedef struct {
        logic        dw, dr;
        logic [31:0] da, dwd;
        logic [7:0]  dm;
        logic        fr;
        logic [31:0] fa;
        logic        mr, mv;
        logic [31:0] mrd;
        logic        ew, er;
        logic [31:0] ea, ewd;
        logic [7:0]  em;
        logic        edr, efr, edv;
        logic [31:0] edd;
        logic        efv;
        logic [31:0] efd;
        logic [2:0]  eo;
        logic        ee;
    } vec_t;

    vec_t tbl [13];
    vec_t seq_a [12];
    vec_t seq_b [8];
    vec_t seq_c [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive_idle();
        d_write_in = 0; d_read_in = 0; d_addr_in = 0; d_wdata_in = 0; d_mask_in = 0;
        f_read_in = 0; f_addr_in = 0; m_ready_in = 0; m_rvalid_in = 0; m_rdata_in = 0;
    endtask

    task automatic apply(input string tag, input vec_t v);
        @(negedge clk);
        d_write_in = v.dw; d_read_in = v.dr; d_addr_in = v.da; d_wdata_in = v.dwd;
        d_mask_in = v.dm; f_read_in = v.fr; f_addr_in = v.fa; m_ready_in = v.mr;
        m_rvalid_in = v.mv; m_rdata_in = v.mrd;
        #1;
        chk({tag, ".m_write"},  32'(m_write_out),     32'(v.ew));
        chk({tag, ".m_read"},   32'(m_read_out),      32'(v.er));
        chk({tag, ".m_addr"},   m_addr_out,           v.ea);
        chk({tag, ".m_wdata"},  m_wdata_out,          v.ewd);
        chk({tag, ".m_mask"},   32'(m_mask_out),      32'(v.em));
        chk({tag, ".d_ready"},  32'(d_ready_out),     32'(v.edr));
        chk({tag, ".f_ready"},  32'(f_ready_out),     32'(v.efr));
        chk({tag, ".d_rvalid"}, 32'(d_rvalid_out),    32'(v.edv));
        chk({tag, ".d_rdata"},  d_rdata_out,          v.edd);
        chk({tag, ".f_rvalid"}, 32'(f_rvalid_out),    32'(v.efv));
        chk({tag, ".f_rdata"},  f_rdata_out,          v.efd);
        chk({tag, ".outstanding"}, 32'(outstanding_out), 32'(v.eo));
        chk({tag, ".error"},    32'(error_out),       32'(v.ee));
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive_idle();
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // dw dr da dwd dm | fr fa | mr mv mrd || ew er ea ewd em | edr efr edv edd efv efd | eo ee
        tbl[0]  = '{0,0,0,0,0, 0,0, 0,0,0,                         0,0,0,0,0, 0,0,0,0,0,0, 0,0};
        tbl[1]  = '{0,1,'h100,0,0, 0,0, 1,0,0,                     0,1,'h100,0,0, 1,0,0,0,0,0, 0,0};
        tbl[2]  = '{0,0,0,0,0, 0,0, 0,1,'hDEADBEEF,                0,0,0,0,0, 0,0,1,'hDEADBEEF,0,0, 1,0};
        tbl[3]  = '{0,1,'h200,5,1, 1,'h300, 1,0,0,                 0,1,'h300,0,0, 0,1,0,0,0,0, 0,0};
        tbl[4]  = '{0,1,'h200,5,1, 1,'h300, 1,0,0,                 0,1,'h200,5,1, 1,0,0,0,0,0, 1,0};
        tbl[5]  = '{0,1,'h200,5,1, 1,'h300, 1,1,'h11,              0,1,'h300,0,0, 0,1,0,0,1,'h11, 2,0};
        tbl[6]  = '{0,0,0,0,0, 0,0, 0,1,'h22,                      0,0,0,0,0, 0,0,1,'h22,0,0, 2,0};
        tbl[7]  = '{0,0,0,0,0, 0,0, 0,1,'h33,                      0,0,0,0,0, 0,0,0,0,1,'h33, 1,0};
        tbl[8]  = '{1,1,'h40,'hCAFE,3, 0,0, 1,0,0,                 1,0,'h40,'hCAFE,3, 1,0,0,0,0,0, 0,0};
        tbl[9]  = '{0,0,0,0,0, 0,0, 0,0,0,                         0,0,0,0,0, 0,0,0,0,0,0, 0,0};
        tbl[10] = '{0,0,0,0,0, 1,'h60, 0,0,0,                      0,1,'h60,0,0, 0,0,0,0,0,0, 0,0};
        tbl[11] = '{0,0,0,0,0, 0,0, 0,1,'h44,                      0,0,0,0,0, 0,0,0,0,0,0, 0,0};
        tbl[12] = '{0,0,0,0,0, 0,0, 0,0,0,                         0,0,0,0,0, 0,0,0,0,0,0, 0,1};

        for (int i = 0; i < 3; i++)
            seq_a[i] = '{0,1,'hA0,0,0, 1,'hB0, 0,0,0,              0,1,'hA0,0,0, 0,0,0,0,0,0, 0,0};
        seq_a[3]  = '{0,1,'hA0,0,0, 1,'hB0, 1,0,0,                 0,1,'hA0,0,0, 1,0,0,0,0,0, 0,0};
        seq_a[4]  = '{0,1,'hA0,0,0, 1,'hB0, 1,0,0,                 0,1,'hB0,0,0, 0,1,0,0,0,0, 1,0};
        seq_a[5]  = '{0,1,'hA0,0,0, 1,'hB0, 1,0,0,                 0,1,'hA0,0,0, 1,0,0,0,0,0, 2,0};
        seq_a[6]  = '{0,1,'hA0,0,0, 1,'hB0, 1,0,0,                 0,1,'hB0,0,0, 0,1,0,0,0,0, 3,0};
        seq_a[7]  = '{0,0,0,0,0, 0,0, 0,1,'h1,                     0,0,0,0,0, 0,0,1,'h1,0,0, 4,0};
        seq_a[8]  = '{0,0,0,0,0, 0,0, 0,1,'h2,                     0,0,0,0,0, 0,0,0,0,1,'h2, 3,0};
        seq_a[9]  = '{0,0,0,0,0, 0,0, 0,1,'h3,                     0,0,0,0,0, 0,0,1,'h3,0,0, 2,0};
        seq_a[10] = '{0,0,0,0,0, 0,0, 0,1,'h4,                     0,0,0,0,0, 0,0,0,0,1,'h4, 1,0};
        seq_a[11] = '{0,0,0,0,0, 0,0, 0,0,0,                       0,0,0,0,0, 0,0,0,0,0,0, 0,0};

        for (int i = 0; i < 4; i++)
            seq_b[i] = '{0,0,0,0,0, 1,'hC0, 1,0,0,                 0,1,'hC0,0,0, 0,1,0,0,0,0, 3'(i),0};
        seq_b[4] = '{0,0,0,0,0, 1,'hC0, 1,0,0,                     0,0,'hC0,0,0, 0,0,0,0,0,0, 4,0};
        seq_b[5] = '{1,0,'h20,'h12345678,'h0F, 1,'hC0, 1,0,0,      1,0,'h20,'h12345678,'h0F, 1,0,0,0,0,0, 4,0};
        seq_b[6] = '{0,0,0,0,0, 1,'hC0, 1,1,'h55,                  0,0,'hC0,0,0, 0,0,0,0,1,'h55, 4,0};
        seq_b[7] = '{0,0,0,0,0, 0,0, 0,1,'h66,                     0,0,0,0,0, 0,0,0,0,1,'h66, 3,0};

        seq_c[0] = '{0,0,0,0,0, 0,0, 0,1,'h77,                     0,0,0,0,0, 0,0,0,0,0,0, 0,0};
        seq_c[1] = '{0,0,0,0,0, 0,0, 0,0,0,                        0,0,0,0,0, 0,0,0,0,0,0, 0,1};

        drive_idle();
        reset = 1'b0;
        #23;
        reset = 1'b1;

        for (int i = 0; i < 13; i++) apply($sformatf("tbl%0d", i), tbl[i]);

        do_reset();
        for (int i = 0; i < 12; i++) apply($sformatf("rr%0d", i), seq_a[i]);
        for (int i = 0; i < 8; i++) apply($sformatf("full%0d", i), seq_b[i]);

        // Asynchronous reset in the middle of a cycle with 2 reads still in flight.
        @(negedge clk);
        d_read_in = 1; d_addr_in = 'h1; m_ready_in = 1; m_rvalid_in = 1; m_rdata_in = 'h99;
        #2;
        reset = 1'b0;
        #1;
        chk("rst.d_ready",     32'(d_ready_out),     0);
        chk("rst.f_ready",     32'(f_ready_out),     0);
        chk("rst.d_rvalid",    32'(d_rvalid_out),    0);
        chk("rst.f_rvalid",    32'(f_rvalid_out),    0);
        chk("rst.outstanding", 32'(outstanding_out), 0);
        chk("rst.error",       32'(error_out),       0);
        @(negedge clk);
        drive_idle();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) apply($sformatf("post%0d", i), seq_c[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of all ports.
REQ-002 Parameter DATA_W, default 32, read/write data width.
REQ-003 Parameter MASK_W, default 8, byte-write mask width.
REQ-004 Parameter MAX_OUT, default 4, max outstanding reads (power of two, >=2).
REQ-005 One clock; reset is asynchronous and active-low; ports named clk and reset.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 d_write_in, d_read_in  in  1 each  execute-stage store/load request, held until accepted.
REQ-009 d_addr_in  in  ADDR_W; d_wdata_in  in  DATA_W; d_mask_in  in  MASK_W  execute-stage request payload.
REQ-010 d_ready_out  out  1  execute-stage request accepted this cycle.
REQ-011 d_rvalid_out  out  1; d_rdata_out  out  DATA_W  load response to execute stage.
REQ-012 f_read_in  in  1; f_addr_in  in  ADDR_W  fetch read request, held until accepted.
REQ-013 f_ready_out  out  1; f_rvalid_out  out  1; f_rdata_out  out  DATA_W  fetch accept/response.
REQ-014 m_write_out, m_read_out  out  1; m_addr_out  out  ADDR_W; m_wdata_out  out  DATA_W; m_mask_out  out  MASK_W  shared memory request.
REQ-015 m_ready_in  in  1  memory accepts request; m_rvalid_in  in  1; m_rdata_in  in  DATA_W  in-order read response.
REQ-016 outstanding_out  out  $clog2(MAX_OUT)+1  reads in flight; error_out  out  1  sticky protocol error.

Function
REQ-017 Data requester active when d_write_in|d_read_in; fetch active when f_read_in.
REQ-018 One active requester: it is granted; both active: requester not in last_grant is granted (round-robin).
REQ-019 Grant is combinational; m_* outputs drive granted payload same cycle; no grant -> m_write_out=m_read_out=0, addr/wdata/mask=0.
REQ-020 d_write_in and d_read_in both high: treated as write only.
REQ-021 Fetch drives m_mask_out=0 and m_wdata_out=0.
REQ-022 Transfer accepted when granted & m_ready_in & (write | count<MAX_OUT); ready_out of granted requester = accepted.
REQ-023 Read blocked at count==MAX_OUT even if m_rvalid_in same cycle; m_read_out forced 0 while blocked; write still accepted.
REQ-024 last_grant updates only on accepted transfer; unaccepted grant leaves it unchanged.
REQ-025 Accepted read pushes requester tag into tag FIFO; m_rvalid_in pops head tag; simultaneous push/pop keeps count.
REQ-026 Response routing zero-latency: head tag DATA -> d_rvalid_out=1, d_rdata_out=m_rdata_in; FETCH -> f_* likewise; other rvalid 0, rdata 0.
REQ-027 m_rvalid_in with empty FIFO: response dropped, error_out set, stays 1 until reset.
REQ-028 Writes produce no response and no FIFO entry.
REQ-029 outstanding_out equals FIFO occupancy, registered.

Reset
REQ-030 reset low: FIFO emptied, count=0, last_grant=FETCH (data wins first contention), error_out=0, immediately.
REQ-031 Reset mid-operation discards in-flight tags; later responses follow REQ-027.
REQ-032 All ready/rvalid outputs 0 during reset.

Structure
REQ-033 Package mem_arb_pkg holds enum Req {REQ_DATA=0, REQ_FETCH=1}.
REQ-034 Sub-module req_tag_fifo: 1-bit-wide, MAX_OUT-deep, count/full/empty outputs, async active-low reset.

Verification
REQ-035 Data read only, m_ready_in=1, addr 0x100 -> same cycle m_read_out=1, m_addr_out=0x100, d_ready_out=1; rvalid data 0xDEADBEEF -> d_rvalid_out=1, d_rdata_out=0xDEADBEEF.
REQ-036 Both request continuously after reset, m_ready_in=1 -> grants DATA,FETCH,DATA,FETCH; responses routed in issue order.
REQ-037 m_ready_in=0 for 3 cycles with both requesting -> DATA held granted, last_grant unchanged, FETCH granted next after DATA accepted.
REQ-038 Four fetch reads, no responses -> outstanding_out=4, fifth read blocked; data store addr 0x20 mask 0x0F still accepted.
REQ-039 Reset pulse with 2 reads outstanding, then m_rvalid_in=1 -> no rvalid to either requester, error_out=1.
REQ-040 d_write_in=d_read_in=1 -> m_write_out=1, m_read_out=0, outstanding_out unchanged.
